dft_sequencer: RTL and testbench

Control FSM for the direct-DFT (MAC) datapath. Sequences a transform through four phases: sample load over AXI, cache fill from RAM, the n/k multiply-accumulate sweep, and per-bin result write-back. Drives the RAM mode select, the cache write, the n/k indices fed to the twiddle ROM, and the accumulator enable/clear. It replaces free-running n/k counters with one explicit scheduler that supports a write-back handshake.

---
 rtl/dft_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dft_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_sequencer.sv
// Control sequencer for the direct-DFT MAC datapath. It steps through load, cache fill,
// the n/k multiply-accumulate sweep and per-bin write-back with a res_ready handshake.
module dft_sequencer #(
    parameter int IDX_W = 12,
    parameter int MIN_N = 2
) (
    input  logic             clk,
    input  logic             n_Reset,
    input  logic             start,
    input  logic [IDX_W-1:0] samp_number,
    input  logic             data_loaded,
    input  logic             res_ready,
    output logic             load_nComp,
    output logic             cache_we,
    output logic [IDX_W-1:0] n_index,
    output logic [IDX_W-1:0] k_index,
    output logic             acc_ce,
    output logic             acc_clr,
    output logic             res_we,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [2:0]       dbg_state
);

    // Write-back handshake: a result transfers in any WB cycle where res_ready is high;
    // res_we mirrors res_ready there, and the accumulator clears on that same edge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_COMP = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_e;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(MIN_N);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] nreg_q, nreg_d;
    logic             cfg_err_q, cfg_err_d;

    logic [IDX_W-1:0] idx_last;
    logic             n_last;
    logic             k_last;

    // N_reg is at least MIN_N while busy, so N_reg-1 never underflows
    assign idx_last = nreg_q - IDX_ONE;
    assign n_last   = (n_q == idx_last);
    assign k_last   = (k_q == idx_last);

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            nreg_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            nreg_q    <= nreg_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        nreg_d    = nreg_q;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (samp_number < IDX_MIN) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        nreg_d  = samp_number;
                        n_d     = '0;
                        k_d     = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (data_loaded) begin
                    n_d     = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (n_last) begin
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_COMP;
                end else begin
                    n_d = n_q + IDX_ONE;
                end
            end
            S_COMP: begin
                if (n_last) begin
                    n_d     = '0;
                    state_d = S_WB;
                end else begin
                    n_d = n_q + IDX_ONE;
                end
            end
            S_WB: begin
                if (res_ready) begin
                    n_d = '0;
                    if (k_last) begin
                        k_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + IDX_ONE;
                        state_d = S_COMP;
                    end
                end
            end
            S_DONE: begin
                n_d     = '0;
                k_d     = '0;
                state_d = S_IDLE;
            end
            default: begin
                n_d     = '0;
                k_d     = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        load_nComp = 1'b1;
        cache_we   = 1'b0;
        acc_ce     = 1'b0;
        acc_clr    = 1'b0;
        res_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy    = 1'b0;
                acc_clr = 1'b1;
            end
            S_LOAD: begin
                acc_clr = 1'b1;
            end
            S_FILL: begin
                cache_we = 1'b1;
                acc_clr  = 1'b1;
            end
            S_COMP: begin
                load_nComp = 1'b0;
                acc_ce     = 1'b1;
            end
            S_WB: begin
                load_nComp = 1'b0;
                res_we     = res_ready;
                acc_clr    = res_ready;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                acc_clr = 1'b1;
            end
        endcase
    end

    assign n_index   = n_q;
    assign k_index   = k_q;
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dft_sequencer.sv
// Directed bench for dft_sequencer: a per-cycle vector table for a short N=2 run,
// followed by sequences for the N=4, stall, ignored-start, mid-run reset and N=4095 cases.
module tb_dft_sequencer;

    localparam int IDX_W = 12;

    // flag order: load_nComp, cache_we, acc_ce, acc_clr, res_we, busy, done, cfg_err
    localparam logic [7:0] F_IDLE  = 8'b1001_0000;
    localparam logic [7:0] F_ERR   = 8'b1001_0001;
    localparam logic [7:0] F_LOAD  = 8'b1001_0100;
    localparam logic [7:0] F_FILL  = 8'b1101_0100;
    localparam logic [7:0] F_COMP  = 8'b0010_0100;
    localparam logic [7:0] F_WBR   = 8'b0001_1100;
    localparam logic [7:0] F_WBS   = 8'b0000_0100;
    localparam logic [7:0] F_DONE  = 8'b1000_0110;

    typedef struct {
        logic             st;
        logic [IDX_W-1:0] sn;
        logic             dl;
        logic             rr;
        logic [7:0]       flags;
        logic [IDX_W-1:0] n;
        logic [IDX_W-1:0] k;
    } vec_t;

    logic             clk = 1'b0;
    logic             n_Reset;
    logic             start;
    logic [IDX_W-1:0] samp_number;
    logic             data_loaded;
    logic             res_ready;
    logic             load_nComp;
    logic             cache_we;
    logic [IDX_W-1:0] n_index;
    logic [IDX_W-1:0] k_index;
    logic             acc_ce;
    logic             acc_clr;
    logic             res_we;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [2:0]       dbg_state;

    int checks = 0;
    int failures = 0;

    // monitor counters
    bit mon_en = 1'b0;
    int m_fill, m_fill_err, m_compwb, m_we, m_we_err, m_done;
    int m_busy, m_busy_rise, m_bad_we, m_max_n, m_max_k;
    bit m_prev_busy;

    always #5 clk = ~clk;

    dft_sequencer #(.IDX_W(IDX_W), .MIN_N(2)) dut (
        .clk(clk), .n_Reset(n_Reset), .start(start), .samp_number(samp_number),
        .data_loaded(data_loaded), .res_ready(res_ready), .load_nComp(load_nComp),
        .cache_we(cache_we), .n_index(n_index), .k_index(k_index), .acc_ce(acc_ce),
        .acc_clr(acc_clr), .res_we(res_we), .busy(busy), .done(done),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    function automatic logic [31:0] pack_out();
        return {load_nComp, cache_we, acc_ce, acc_clr, res_we, busy, done, cfg_err,
                n_index, k_index};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        m_fill = 0; m_fill_err = 0; m_compwb = 0; m_we = 0; m_we_err = 0; m_done = 0;
        m_busy = 0; m_busy_rise = 0; m_bad_we = 0; m_max_n = 0; m_max_k = 0;
        m_prev_busy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                m_busy++;
                if (int'(n_index) > m_max_n) m_max_n = int'(n_index);
                if (int'(k_index) > m_max_k) m_max_k = int'(k_index);
            end
            if (busy && !m_prev_busy) m_busy_rise++;
            m_prev_busy = busy;
            if (cache_we) begin
                if (int'(n_index) != m_fill) m_fill_err++;
                m_fill++;
            end
            if (!load_nComp) m_compwb++;
            if (res_we) begin
                if (int'(k_index) != m_we) m_we_err++;
                m_we++;
            end
            if (res_we && !res_ready) m_bad_we++;
            if (done) m_done++;
        end
    end

    // Full transform: start, data_loaded dl_delay cycles later, optional res_ready stall
    // at bin stall_k, optional start/samp_number=8 pokes during COMP of bin 1.
    task automatic run_xfer(input int n, input int dl_delay, input int stall_k,
                            input int stall_len, input bit poke, input string tag);
        int cyc;
        int stalled;
        bit in_wb;
        cyc = 0;
        stalled = 0;
        mon_clear();
        mon_en = 1'b1;
        step();
        start = 1'b1; samp_number = IDX_W'(n); res_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < dl_delay; i++) step();
        data_loaded = 1'b1;
        step();
        data_loaded = 1'b0;
        while (m_done == 0 && cyc < 2000) begin
            in_wb = busy && !load_nComp && !acc_ce;
            if (in_wb && int'(k_index) == stall_k && stalled < stall_len) begin
                res_ready = 1'b0;
                stalled++;
            end else begin
                res_ready = 1'b1;
            end
            if (poke && acc_ce && k_index == 12'd1) begin
                start = 1'b1; samp_number = 12'd8;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        res_ready = 1'b1;
        mon_en = 1'b0;
        check({tag, " done_pulses"}, m_done, 1);
        check({tag, " idle_after"}, {31'd0, busy}, 0);
        check({tag, " fill_cycles"}, m_fill, n);
        check({tag, " fill_order"}, m_fill_err, 0);
        check({tag, " compwb_cycles"}, m_compwb, n * (n + 1) + stall_len);
        check({tag, " res_we_count"}, m_we, n);
        check({tag, " res_we_k_order"}, m_we_err, 0);
        check({tag, " res_we_without_ready"}, m_bad_we, 0);
        check({tag, " busy_cycles"}, m_busy, dl_delay + n + n * (n + 1) + stall_len + 1);
        check({tag, " busy_contiguous"}, m_busy_rise, 1);
        check({tag, " max_n"}, m_max_n, n - 1);
        check({tag, " max_k"}, m_max_k, n - 1);
    endtask

    vec_t vecs[19];

    initial begin
        int cnt;
        int maxn;
        int lastn;
        n_Reset = 1'b0; start = 1'b0; samp_number = '0; data_loaded = 1'b0; res_ready = 1'b1;

        vecs[0]  = '{1'b0, 12'd0, 1'b1, 1'b1, F_IDLE, 12'd0, 12'd0};
        vecs[1]  = '{1'b1, 12'd1, 1'b0, 1'b1, F_IDLE, 12'd0, 12'd0};
        vecs[2]  = '{1'b0, 12'd1, 1'b0, 1'b1, F_ERR,  12'd0, 12'd0};
        vecs[3]  = '{1'b1, 12'd0, 1'b0, 1'b1, F_IDLE, 12'd0, 12'd0};
        vecs[4]  = '{1'b0, 12'd0, 1'b0, 1'b1, F_ERR,  12'd0, 12'd0};
        vecs[5]  = '{1'b1, 12'd2, 1'b0, 1'b1, F_IDLE, 12'd0, 12'd0};
        vecs[6]  = '{1'b0, 12'd2, 1'b0, 1'b1, F_LOAD, 12'd0, 12'd0};
        vecs[7]  = '{1'b0, 12'd2, 1'b1, 1'b1, F_LOAD, 12'd0, 12'd0};
        vecs[8]  = '{1'b0, 12'd2, 1'b1, 1'b1, F_FILL, 12'd0, 12'd0};
        vecs[9]  = '{1'b0, 12'd9, 1'b0, 1'b1, F_FILL, 12'd1, 12'd0};
        vecs[10] = '{1'b0, 12'd9, 1'b0, 1'b1, F_COMP, 12'd0, 12'd0};
        vecs[11] = '{1'b1, 12'd3, 1'b0, 1'b1, F_COMP, 12'd1, 12'd0};
        vecs[12] = '{1'b0, 12'd3, 1'b0, 1'b1, F_WBR,  12'd0, 12'd0};
        vecs[13] = '{1'b0, 12'd3, 1'b0, 1'b1, F_COMP, 12'd0, 12'd1};
        vecs[14] = '{1'b0, 12'd3, 1'b0, 1'b1, F_COMP, 12'd1, 12'd1};
        vecs[15] = '{1'b0, 12'd3, 1'b0, 1'b0, F_WBS,  12'd0, 12'd1};
        vecs[16] = '{1'b0, 12'd3, 1'b0, 1'b1, F_WBR,  12'd0, 12'd1};
        vecs[17] = '{1'b0, 12'd3, 1'b0, 1'b1, F_DONE, 12'd0, 12'd0};
        vecs[18] = '{1'b0, 12'd3, 1'b0, 1'b1, F_IDLE, 12'd0, 12'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", pack_out(), {F_IDLE, 12'd0, 12'd0});
        @(negedge clk);
        n_Reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step();
            start = vecs[i].st; samp_number = vecs[i].sn;
            data_loaded = vecs[i].dl; res_ready = vecs[i].rr;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_out(), {vecs[i].flags, vecs[i].n, vecs[i].k});
        end
        step();
        start = 1'b0; data_loaded = 1'b0; res_ready = 1'b1;

        run_xfer(4, 3, -1, 0, 1'b0, "n4");
        run_xfer(3, 2, 1, 5, 1'b0, "n3_stall");
        run_xfer(4, 1, -1, 0, 1'b1, "n4_start_ignored");

        // abort by reset in COMP at k=2, n=1
        step();
        start = 1'b1; samp_number = 12'd4;
        step();
        start = 1'b0; data_loaded = 1'b1;
        step();
        data_loaded = 1'b0;
        cnt = 0;
        while (!(acc_ce && k_index == 12'd2 && n_index == 12'd1) && cnt < 200) begin
            step();
            cnt++;
        end
        check("rst_reach_k2n1", {31'd0, acc_ce && k_index == 12'd2 && n_index == 12'd1}, 1);
        #2;
        n_Reset = 1'b0;
        #1;
        check("rst_async_outputs", pack_out(), {F_IDLE, 12'd0, 12'd0});
        @(negedge clk);
        n_Reset = 1'b1;
        step();
        check("rst_idle_after", pack_out(), {F_IDLE, 12'd0, 12'd0});
        run_xfer(2, 1, -1, 0, 1'b0, "n2_after_rst");

        // N=4095: fill sweep and the first bin, then abort by reset
        step();
        start = 1'b1; samp_number = 12'd4095;
        step();
        start = 1'b0; data_loaded = 1'b1;
        step();
        data_loaded = 1'b0;
        cnt = 0; maxn = 0;
        while (cache_we && cnt < 5000) begin
            if (int'(n_index) > maxn) maxn = int'(n_index);
            cnt++;
            step();
        end
        check("big_fill_cycles", cnt, 4095);
        check("big_fill_max_n", maxn, 4094);
        check("big_comp_entry", pack_out(), {F_COMP, 12'd0, 12'd0});
        cnt = 0; lastn = 0;
        while (acc_ce && cnt < 5000) begin
            lastn = int'(n_index);
            cnt++;
            step();
        end
        check("big_comp_cycles", cnt, 4095);
        check("big_comp_last_n", lastn, 4094);
        check("big_wb_entry", pack_out(), {F_WBR, 12'd0, 12'd0});
        n_Reset = 1'b0;
        #1;
        check("big_reset", pack_out(), {F_IDLE, 12'd0, 12'd0});
        @(negedge clk);
        n_Reset = 1'b1;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
